// File: rtl/pattern_store.sv
// rtl/pattern_store.sv - depth-addressable pattern store with append, stream playback and guess checking
module pattern_store #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             append_en,
  input  logic [WIDTH-1:0] append_data,
  input  logic             play_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  input  logic             check_start,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] guess_data,
  output logic             match,
  output logic             mismatch,
  output logic             check_done,
  output logic [LW-1:0]    len,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx, idx_nxt;
  logic [LW-1:0]    len_q, len_nxt;
  logic             match_q, match_nxt;
  logic             mismatch_q, mismatch_nxt;
  logic             done_q, done_nxt;
  logic             ovf_q, ovf_nxt;
  logic             wr_en;
  logic             at_last;
  logic             full_w, empty_w;
  logic [WIDTH-1:0] cur;

  assign full_w  = (len_q == LW'(DEPTH));
  assign empty_w = (len_q == '0);
  assign at_last = (LW'(idx) == len_q - LW'(1));
  assign cur     = mem[idx];

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    len_nxt      = len_q;
    match_nxt    = 1'b0;
    mismatch_nxt = 1'b0;
    done_nxt     = 1'b0;
    ovf_nxt      = 1'b0;
    wr_en        = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      len_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (append_en) begin
            if (full_w) begin
              ovf_nxt = 1'b1;
            end else begin
              wr_en   = 1'b1;
              len_nxt = len_q + LW'(1);
            end
          end
          // Start decisions look at the length before this cycle's append.
          if (play_start && !empty_w) begin
            state_nxt = S_PLAY;
            idx_nxt   = '0;
          end else if (check_start && !empty_w) begin
            state_nxt = S_CHECK;
            idx_nxt   = '0;
          end
        end
        S_PLAY: begin
          if (out_ready) begin
            if (at_last) state_nxt = S_IDLE;
            else         idx_nxt   = idx + AW'(1);
          end
        end
        S_CHECK: begin
          if (guess_valid) begin
            if (guess_data == cur) begin
              match_nxt = 1'b1;
              if (at_last) begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
              end else begin
                idx_nxt = idx + AW'(1);
              end
            end else begin
              mismatch_nxt = 1'b1;
              state_nxt    = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      len_q      <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      len_q      <= len_nxt;
      match_q    <= match_nxt;
      mismatch_q <= mismatch_nxt;
      done_q     <= done_nxt;
      ovf_q      <= ovf_nxt;
    end
  end

  // Entry storage is deliberately not reset; only len decides what is live.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[len_q[AW-1:0]] <= append_data;
  end

  assign out_valid  = (state == S_PLAY);
  assign out_data   = out_valid ? cur : '0;
  assign out_last   = out_valid && at_last;
  assign busy       = (state != S_IDLE);
  assign len        = len_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign match      = match_q;
  assign mismatch   = mismatch_q;
  assign check_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pattern_store.sv
// tb/tb_pattern_store.sv - directed self-checking bench for pattern_store
module tb_pattern_store;

  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, clear, append_en, play_start, out_ready;
  logic             check_start, guess_valid;
  logic [WIDTH-1:0] append_data, guess_data, out_data;
  logic             out_valid, out_last, match, mismatch, check_done;
  logic [LW-1:0]    len;
  logic             full, empty, busy, overflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  pattern_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .append_en(append_en), .append_data(append_data),
    .play_start(play_start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .check_start(check_start), .guess_valid(guess_valid), .guess_data(guess_data),
    .match(match), .mismatch(mismatch), .check_done(check_done),
    .len(len), .full(full), .empty(empty), .busy(busy), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_play(input string tag, input logic [63:0] d, input logic last);
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " data"}, out_data, d);
    check({tag, " last"}, 64'(out_last), 64'(last));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " valid"}, 64'(out_valid), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " data"}, out_data, 64'd0);
  endtask

  task automatic append(input logic [63:0] d);
    append_en = 1'b1; append_data = d;
    step();
    append_en = 1'b0;
  endtask

  task automatic guess(input logic [63:0] d);
    guess_valid = 1'b1; guess_data = d;
    step();
    guess_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; append_en = 1'b0; append_data = '0;
    play_start = 1'b0; out_ready = 1'b1; check_start = 1'b0;
    guess_valid = 1'b0; guess_data = '0;
    step(); step();
    rst = 1'b0;
    check("rst len", 64'(len), 64'd0);
    check("rst empty", 64'(empty), 64'd1);
    check("rst full", 64'(full), 64'd0);
    check("rst pulses", {60'd0, match, mismatch, check_done, overflow}, 64'd0);
    chk_idle("rst");
    step();

    // Three-entry sequence
    append(64'h11); append(64'h22); append(64'h33);
    check("app len", 64'(len), 64'd3);
    check("app empty", 64'(empty), 64'd0);
    check("app full", 64'(full), 64'd0);

    // Back-to-back playback
    play_start = 1'b1; step(); play_start = 1'b0;
    check("play busy", 64'(busy), 64'd1);
    chk_play("p0", 64'h11, 1'b0); step();
    chk_play("p1", 64'h22, 1'b0); step();
    chk_play("p2", 64'h33, 1'b1); step();
    chk_idle("p end");

    // Playback with two stall cycles on entry 1
    play_start = 1'b1; step(); play_start = 1'b0;
    chk_play("s0", 64'h11, 1'b0); out_ready = 1'b0; step();
    check("s0 hold", out_data, 64'h11); out_ready = 1'b1; step();
    chk_play("s1", 64'h22, 1'b0); out_ready = 1'b0; step();
    chk_play("s1 stall a", 64'h22, 1'b0); step();
    chk_play("s1 stall b", 64'h22, 1'b0); out_ready = 1'b1; step();
    chk_play("s2", 64'h33, 1'b1); step();
    chk_idle("s end");

    // Full correct check
    check_start = 1'b1; step(); check_start = 1'b0;
    check("chk busy", 64'(busy), 64'd1);
    check("chk no valid", 64'(out_valid), 64'd0);
    guess(64'h11);
    check("g0 match", 64'(match), 64'd1);
    check("g0 done", 64'(check_done), 64'd0);
    guess(64'h22);
    check("g1 match", 64'(match), 64'd1);
    guess(64'h33);
    check("g2 match", 64'(match), 64'd1);
    check("g2 done", 64'(check_done), 64'd1);
    check("g2 busy", 64'(busy), 64'd0);
    step();
    check("pulse clr", {61'd0, match, mismatch, check_done}, 64'd0);

    // Wrong second guess
    check_start = 1'b1; step(); check_start = 1'b0;
    guess(64'h11);
    check("w0 match", 64'(match), 64'd1);
    guess(64'h99);
    check("w1 mismatch", 64'(mismatch), 64'd1);
    check("w1 match", 64'(match), 64'd0);
    check("w1 busy", 64'(busy), 64'd0);
    check("w1 len", 64'(len), 64'd3);

    // Fill and overflow
    for (int i = 0; i < DEPTH - 3; i++) append(64'h100 + 64'(i));
    check("fill len", 64'(len), 64'd16);
    check("fill full", 64'(full), 64'd1);
    append(64'hDEAD);
    check("ovf pulse", 64'(overflow), 64'd1);
    check("ovf len", 64'(len), 64'd16);
    step();
    check("ovf clr", 64'(overflow), 64'd0);
    play_start = 1'b1; step(); play_start = 1'b0;
    chk_play("f0", 64'h11, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      step();
      if (i < 3) chk_play("fx", 64'h11 * 64'(i + 1), 1'b0);
      else       chk_play("fx", 64'h100 + 64'(i - 3), i == DEPTH - 1);
    end
    step();
    chk_idle("f end");

    // Clear during playback at entry 1
    play_start = 1'b1; step(); play_start = 1'b0;
    step();
    chk_play("c1", 64'h22, 1'b0);
    clear = 1'b1; step(); clear = 1'b0;
    chk_idle("clr");
    check("clr len", 64'(len), 64'd0);
    check("clr empty", 64'(empty), 64'd1);
    play_start = 1'b1; step(); play_start = 1'b0;
    chk_idle("clr play");

    // Reset during check with a correct guess pending
    append(64'h11);
    check("r len", 64'(len), 64'd1);
    check_start = 1'b1; step(); check_start = 1'b0;
    check("r busy", 64'(busy), 64'd1);
    rst = 1'b1; guess_valid = 1'b1; guess_data = 64'h11;
    step();
    rst = 1'b0; guess_valid = 1'b0;
    chk_idle("rst chk");
    check("rst chk len", 64'(len), 64'd0);
    check("rst chk pulses", {61'd0, match, mismatch, check_done}, 64'd0);
    play_start = 1'b1; step(); play_start = 1'b0;
    chk_idle("rst play");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
